// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM state encoding and default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: AND/OR/ADD/SUB, unknown opcodes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [3:0]       ALU_control,
  output logic [WIDTH-1:0] Aout,
  output logic             zeroFlag
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves Aout unassigned (no latch).
    Aout = '0;
    case (ALU_control)
      ALU_AND: Aout = a1 & a2;
      ALU_OR:  Aout = a1 | a2;
      ALU_ADD: Aout = a1 + a2;
      ALU_SUB: Aout = a1 - a2;
      default: Aout = '0;
    endcase
  end

  assign zeroFlag = (Aout == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; 'last' remembers the previous winner and flips priority.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant0,
  output logic grant1
);

  logic last;

  // With both requesting, the one that did not win last time goes next.
  assign grant0 = req0 & (~req1 | last);
  assign grant1 = req1 & (~req0 | ~last);

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant1;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler for two requesters sharing one ALU, with a registered tagged response.
// Define ALU_SCHED_PIPE_EN to accept a new request in the same cycle a response is consumed.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [3:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [3:0]       r1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  state_t           state, state_next;
  logic             arb_en;
  logic             grant0, grant1;
  logic             accept;
  logic             sel;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_op;
  logic             alu_zero;

`ifdef ALU_SCHED_PIPE_EN
  // A response leaving this cycle frees the register for a new result at the same edge.
  assign arb_en = ~reset & ((state == ST_IDLE) | rsp_ready);
`else
  assign arb_en = ~reset & (state == ST_IDLE);
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (r0_valid),
    .req1   (r1_valid),
    .update (accept),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign r0_ready = arb_en & grant0;
  assign r1_ready = arb_en & grant1;
  assign accept   = r0_ready | r1_ready;
  assign sel      = grant1;

  always_comb begin
    alu_a  = sel ? r1_a  : r0_a;
    alu_b  = sel ? r1_b  : r0_b;
    alu_op = sel ? r1_op : r0_op;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a1          (alu_a),
    .a2          (alu_b),
    .ALU_control (alu_op),
    .Aout        (alu_out),
    .zeroFlag    (alu_zero)
  );

  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready && !accept) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (accept) begin
      rsp_id     <= sel;
      rsp_result <= alu_out;
      rsp_zero   <= alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: cycle model compared on every negedge plus directed literal checks.
module tb_alu_scheduler;
  import alu_pkg::*;

`ifdef ALU_SCHED_PIPE_EN
  localparam bit PIPE = 1'b1;
  localparam int GAP  = 1;
`else
  localparam bit PIPE = 1'b0;
  localparam int GAP  = 2;
`endif

  logic        clk;
  logic        reset;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_op, r1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;

  alu_scheduler #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_a       (r0_a),
    .r0_b       (r0_b),
    .r0_op      (r0_op),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_a       (r1_a),
    .r1_b       (r1_b),
    .r1_op      (r1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    int          cyc;
  } rsp_t;

  rsp_t rsp_log[$];
  logic grant_log[$];

  // Model: holds at most one response; a free slot (or one being drained, in pipe mode) takes a request.
  bit          m_full = 1'b0;
  bit          m_last = 1'b1;
  logic        m_id;
  logic [31:0] m_res;
  logic        m_zero;
  bit          m_can, m_g0, m_g1;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check_b("rst_rsp_valid", rsp_valid, 1'b0);
      check_b("rst_r0_ready", r0_ready, 1'b0);
      check_b("rst_r1_ready", r1_ready, 1'b0);
      check_b("rst_rsp_id", rsp_id, 1'b0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check_b("rst_rsp_zero", rsp_zero, 1'b0);
      m_full = 1'b0;
      m_last = 1'b1;
    end else begin
      m_can = !m_full || (PIPE && rsp_ready);
      m_g0  = m_can && r0_valid && (!r1_valid || m_last);
      m_g1  = m_can && r1_valid && (!r0_valid || !m_last);
      check_b("model_rsp_valid", rsp_valid, m_full);
      check_b("model_r0_ready", r0_ready, m_g0);
      check_b("model_r1_ready", r1_ready, m_g1);
      if (m_full) begin
        check_b("model_rsp_id", rsp_id, m_id);
        check("model_rsp_result", rsp_result, m_res);
        check_b("model_rsp_zero", rsp_zero, m_zero);
      end
      if (rsp_valid && rsp_ready) rsp_log.push_back('{rsp_id, rsp_result, rsp_zero, cyc});
      if (r0_valid && r0_ready) grant_log.push_back(1'b0);
      if (r1_valid && r1_ready) grant_log.push_back(1'b1);
      if (m_g0 || m_g1) begin
        m_full = 1'b1;
        m_id   = m_g1;
        m_res  = m_g1 ? alu_ref(r1_op, r1_a, r1_b) : alu_ref(r0_op, r0_a, r0_b);
        m_zero = (m_res == 32'd0);
        m_last = m_g1;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n, guard;
  logic acc;

  initial begin
    reset = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    r0_a = '0; r0_b = '0; r0_op = '0;
    r1_a = '0; r1_b = '0; r1_op = '0;

    tick();
    r0_valid = 1'b1;
    #1 check_b("rst_forces_ready_low", r0_ready, 1'b0);
    tick();
    tick();
    r0_valid = 1'b0;
    reset = 1'b0;

    // Single ADD 5+7 from r0
    tick();
    r0_valid = 1'b1; r0_op = ALU_ADD; r0_a = 32'd5; r0_b = 32'd7; rsp_ready = 1'b1;
    #1 check_b("t1_r0_ready", r0_ready, 1'b1);
    check_b("t1_r1_ready", r1_ready, 1'b0);
    tick();
    r0_valid = 1'b0;
    #1 check_b("t1_rsp_valid", rsp_valid, 1'b1);
    check_b("t1_rsp_id", rsp_id, 1'b0);
    check("t1_rsp_result", rsp_result, 32'd12);
    check_b("t1_rsp_zero", rsp_zero, 1'b0);
    tick();
    check_b("t1_back_idle", rsp_valid, 1'b0);

    // Restore last=1 so r0 wins the first contested grant
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Both requesters valid continuously
    grant_log.delete();
    rsp_log.delete();
    r0_op = ALU_SUB; r0_a = 32'd9;    r0_b = 32'd9;
    r1_op = ALU_OR;  r1_a = 32'hF0;   r1_b = 32'h0F;
    r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1;
    repeat (6) tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (2) tick();
    check_b("t2_three_grants", grant_log.size() >= 3, 1'b1);
    for (int i = 0; i < 3 && i < grant_log.size(); i++)
      check_b($sformatf("t2_grant%0d", i), grant_log[i], (i % 2) == 1);
    check_b("t2_two_rsps", rsp_log.size() >= 2, 1'b1);
    if (rsp_log.size() >= 2) begin
      check_b("t2_rsp0_id", rsp_log[0].id, 1'b0);
      check("t2_rsp0_result", rsp_log[0].res, 32'd0);
      check_b("t2_rsp0_zero", rsp_log[0].zero, 1'b1);
      check_b("t2_rsp1_id", rsp_log[1].id, 1'b1);
      check("t2_rsp1_result", rsp_log[1].res, 32'hFF);
      check_b("t2_rsp1_zero", rsp_log[1].zero, 1'b0);
      check("t2_rsp_gap", rsp_log[1].cyc - rsp_log[0].cyc, GAP);
    end

    // Back-pressure: response held stable, pending r1 waits
    r0_op = ALU_AND; r0_a = 32'h0F0F; r0_b = 32'hFF00;
    r0_valid = 1'b1; rsp_ready = 1'b0;
    #1 check_b("t3_r0_ready", r0_ready, 1'b1);
    tick();
    r0_valid = 1'b0;
    r1_op = ALU_ADD; r1_a = 32'd1; r1_b = 32'd2; r1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_b("t3_hold_valid", rsp_valid, 1'b1);
      check_b("t3_hold_id", rsp_id, 1'b0);
      check("t3_hold_result", rsp_result, 32'h0F00);
      check_b("t3_hold_r0_ready", r0_ready, 1'b0);
      check_b("t3_hold_r1_ready", r1_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check_b("t3_r1_ready_hs", r1_ready, PIPE);
    check("t3_hs_result", rsp_result, 32'h0F00);
    tick();
`ifdef ALU_SCHED_PIPE_EN
    r1_valid = 1'b0;
`else
    #1 check_b("t3_r1_ready_after", r1_ready, 1'b1);
    check_b("t3_idle_gap", rsp_valid, 1'b0);
    tick();
    r1_valid = 1'b0;
`endif
    #1 check_b("t3_r1_rsp_id", rsp_id, 1'b1);
    check("t3_r1_rsp_result", rsp_result, 32'd3);
    tick();

    // Wrap-around subtract, then unknown opcode
    r1_op = ALU_SUB; r1_a = 32'd0; r1_b = 32'd1; r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    #1 check("t4_sub_result", rsp_result, 32'hFFFF_FFFF);
    check_b("t4_sub_zero", rsp_zero, 1'b0);
    check_b("t4_sub_id", rsp_id, 1'b1);
    tick();
    r0_op = 4'b1111; r0_a = 32'd3; r0_b = 32'd4; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    #1 check_b("t4_bad_valid", rsp_valid, 1'b1);
    check("t4_bad_result", rsp_result, 32'd0);
    check_b("t4_bad_zero", rsp_zero, 1'b1);
    tick();

    // Reset while a response is held
    r0_op = ALU_ADD; r0_a = 32'd2; r0_b = 32'd2; r0_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    r1_valid = 1'b1;
    #1 check_b("t5_pre_valid", rsp_valid, 1'b1);
    reset = 1'b1;
    #1 check_b("t5_async_valid", rsp_valid, 1'b0);
    check_b("t5_rst_r0_ready", r0_ready, 1'b0);
    check_b("t5_rst_r1_ready", r1_ready, 1'b0);
    check("t5_rst_result", rsp_result, 32'd0);
    tick();
    reset = 1'b0;
    #1 check_b("t5_r0_first", r0_ready, 1'b1);
    check_b("t5_r1_waits", r1_ready, 1'b0);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1 check_b("t5_rsp_id", rsp_id, 1'b0);
    check("t5_rsp_result", rsp_result, 32'd4);
    rsp_ready = 1'b1;
    repeat (2) tick();

    // Four back-to-back ADDs from r0
    rsp_log.delete();
    r0_op = ALU_ADD; r0_a = 32'd0; r0_b = 32'd10; r0_valid = 1'b1;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 20) begin
      #1 acc = r0_ready;
      tick();
      guard++;
      if (acc) begin
        n++;
        r0_a = n;
      end
    end
    r0_valid = 1'b0;
    check("t6_accepts", n, 4);
    repeat (3) tick();
    check_b("t6_four_rsps", rsp_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++) begin
      check_b($sformatf("t6_id%0d", i), rsp_log[i].id, 1'b0);
      check($sformatf("t6_res%0d", i), rsp_log[i].res, 32'd10 + i);
      if (i > 0) check($sformatf("t6_gap%0d", i), rsp_log[i].cyc - rsp_log[i-1].cyc, GAP);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Two-requester scheduler for the shared 32-bit ALU in the datapath. It accepts operation requests from two independent requesters over valid/ready handshakes and arbitrates round-robin. It drives the selected operands and opcode into the `alu` instance and registers the result and zero flag. It returns the result on a single tagged response channel.

## Interface
- `WIDTH`, 32, operand/result width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `r0_valid` / `r1_valid`  in  1  request valid, requester 0 / 1
- `r0_ready` / `r1_ready`  out  1  request accepted this cycle
- `r0_a`, `r0_b` / `r1_a`, `r1_b`  in  WIDTH  operands
- `r0_op` / `r1_op`  in  4  opcode: AND 0000, OR 0001, ADD 0010, SUB 0110
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  1  requester that owns the response
- `rsp_result`  out  WIDTH  ALU result
- `rsp_zero`  out  1  result == 0

## Operation
- FSM states:
  - IDLE: no response held.
  - RESP: response register full, waiting for `rsp_ready`.
- IDLE:
  - If any `rN_valid` is high, grant one requester and assert its `rN_ready` combinationally.
  - On the clock edge: capture the ALU output into `rsp_result`/`rsp_zero`, set `rsp_id` to the winner, go to RESP.
- RESP:
  - `rsp_valid`=1. All `rN_ready`=0, except as described under Configuration.
  - On `rsp_valid && rsp_ready`: go to IDLE.
- Arbitration:
  - `last` register, reset value 1.
  - Only one requester valid: grant it.
  - Both valid: grant `~last`.
  - `last` updates to the winner on every grant.
- ALU function:
  - AND, OR, ADD, SUB. ADD/SUB wrap modulo 2^WIDTH, carry discarded.
  - Any other opcode gives result 0, zero=1. The request is still accepted and answered.
- Response outputs are stable while `rsp_valid && !rsp_ready`.
- Requesters may drop `rN_valid` before they are granted. No request is lost after its `rN_ready`.
- Reset, from any state and mid-transaction: state=IDLE, `last`=1, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0. `r0_ready`/`r1_ready` are forced to 0 while `reset` is high. A held response is discarded.

## Timing
- Request accepted in cycle N → `rsp_valid` high from cycle N+1.
- Without `ALU_SCHED_PIPE_EN`: maximum throughput is one operation per 2 cycles. The response handshake in cycle M lets the next accept happen in M+1.
- `rN_ready` depends combinationally on `rN_valid`, the other requester's valid, state and `last`. Requesters must not make `valid` depend on `ready`.
- No combinational path from request inputs to response outputs.

## Configuration
- `ALU_SCHED_PIPE_EN` defined:
  - In RESP with `rsp_ready`=1, the arbiter also grants a pending request in that same cycle.
  - The response register reloads and the FSM stays in RESP.
  - Sustained throughput is 1 operation per cycle.
- `ALU_SCHED_PIPE_EN` undefined: behaviour exactly as in Operation. Ready is only ever asserted in IDLE.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`;
  - the state encoding (`ST_IDLE`, `ST_RESP`);
  - default `WIDTH`.
- Sub-modules:
  - One natural sub-module, `rr_arb2`: two-input round-robin arbiter with `last` register, grant outputs and an update strobe.
  - The ALU computation uses the existing `alu` module instance: `a1`, `a2`, `ALU_control`, `Aout`, `zeroFlag`.

## Test plan
- Reset released; `r0` requests ADD 5+7 → `r0_ready`=1 same cycle. Next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12, `rsp_zero`=0.
- Both requesters valid continuously (r0 SUB 9−9, r1 OR 0xF0|0x0F), `rsp_ready`=1:
  - Grants alternate r0, r1, r0.
  - Responses: 0 with zero=1, then 0xFF with zero=0.
  - Without the macro, responses arrive every 2 cycles.
- `rsp_ready` held 0 for 5 cycles after a response → `rsp_*` outputs unchanged. Both `rN_ready`=0. The pending r1 request is accepted the cycle after the handshake, or in the handshake cycle with `ALU_SCHED_PIPE_EN`.
- SUB 0−1 → `rsp_result`=0xFFFFFFFF, `rsp_zero`=0. Opcode 1111 → result 0, zero=1.
- Assert `reset` while in RESP → `rsp_valid`=0 asynchronously, `rN_ready`=0. After release, with both requesters valid, r0 is granted first.
- With `ALU_SCHED_PIPE_EN`: 4 back-to-back r0 ADDs with `rsp_ready`=1 → 4 responses in 4 consecutive cycles, values correct and in order.
